// File: rtl/backprop_engine.sv
// Neuron back-propagation unit: latches one neuron's bundle, derives the sigmoid delta,
// then streams per-input error terms and updated weights, one element per cycle.
module backprop_engine #(
    parameter  int N_INPUTS = 32,
    parameter  int DATA_W   = 16,
    parameter  int FRAC_W   = 8,
    localparam int IDX_W    = $clog2(N_INPUTS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]     bp_dendrites,
    input  logic [(N_INPUTS+1)*DATA_W-1:0] bp_weights,
    input  logic [DATA_W-1:0]              bp_axon,
    input  logic [DATA_W-1:0]              bp_backprop,
    input  logic [4:0]                     bp_rate_shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_idx,
    output logic [DATA_W-1:0]              out_change,
    output logic [DATA_W-1:0]              out_weight,
    output logic                           out_last
);

    localparam int PROD_W = 2 * DATA_W + 2;
    localparam int SAT_W  = PROD_W + 1;

    localparam logic signed [DATA_W-1:0] ONE_D = {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_INPUTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRV,
        S_DELTA,
        S_EMIT
    } state_t;

    function automatic logic signed [DATA_W:0] sx(input logic signed [DATA_W-1:0] v);
        return {v[DATA_W-1], v};
    endfunction

    // Clamp when the bits above the DATA_W sign position disagree with it.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SAT_W-1:0] v);
        if ((&v[SAT_W-1:DATA_W-1]) || !(|v[SAT_W-1:DATA_W-1])) begin
            return v[DATA_W-1:0];
        end
        return v[SAT_W-1] ? MIN_D : MAX_D;
    endfunction

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  dend_q [N_INPUTS];
    logic signed [DATA_W-1:0]  wgt_q  [N_INPUTS+1];
    logic signed [DATA_W-1:0]  axon_q, bprop_q, deriv_q, delta_q;
    logic [4:0]                rate_q;
    logic [IDX_W-1:0]          issue_q;

    logic                      out_valid_q, out_last_q;
    logic [IDX_W-1:0]          out_idx_q;
    logic signed [DATA_W-1:0]  out_change_q, out_weight_q;

    logic signed [DATA_W-1:0]  din [N_INPUTS+1];
    logic signed [DATA_W:0]    mul_a, mul_b, mul_c;
    logic signed [PROD_W-1:0]  prod_ab, prod_ac, shr_ab, shr_ac;
    logic signed [DATA_W-1:0]  w_sel, scal_res, upd_term, upd_shift, w_new;
    logic signed [DATA_W:0]    w_sum;
    logic                      last_sel, out_fire, load;

    // The threshold behaves as one more input tied to +1.0.
    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            din[i] = dend_q[i];
        end
        din[N_INPUTS] = ONE_D;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_sel = wgt_q[issue_q];
        mul_a = sx(delta_q);
        mul_b = sx(w_sel);
        mul_c = sx(din[issue_q]);
        case (state_q)
            S_DRV: begin
                mul_a = sx(axon_q);
                mul_b = sx(ONE_D) - sx(axon_q);
            end
            S_DELTA: begin
                mul_a = sx(bprop_q);
                mul_b = sx(deriv_q);
            end
            default: ;
        endcase
    end

    // prod_ab yields deriv, then delta, then each error term; prod_ac feeds the weight update.
    assign prod_ab   = mul_a * mul_b;
    assign prod_ac   = mul_a * mul_c;
    assign shr_ab    = prod_ab >>> FRAC_W;
    assign shr_ac    = prod_ac >>> FRAC_W;
    assign scal_res  = sat({shr_ab[PROD_W-1], shr_ab});
    assign upd_term  = sat({shr_ac[PROD_W-1], shr_ac});
    assign upd_shift = upd_term >>> rate_q;
    assign w_sum     = sx(w_sel) + sx(upd_shift);
    assign w_new     = sat({{(SAT_W-DATA_W-1){w_sum[DATA_W]}}, w_sum});
    assign last_sel  = (issue_q == LAST_IDX);

    assign out_fire  = out_valid_q && out_ready;
    assign load      = (state_q == S_EMIT) && (!out_valid_q || out_ready) && !(out_fire && out_last_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_DRV;
            S_DRV:   state_d = S_DELTA;
            S_DELTA: state_d = S_EMIT;
            S_EMIT:  if (out_fire && out_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            // NOTE: operand arrays are plain flops rather than a RAM, so clearing them here is safe.
            for (int i = 0; i < N_INPUTS; i++) begin
                dend_q[i] <= '0;
            end
            for (int i = 0; i <= N_INPUTS; i++) begin
                wgt_q[i] <= '0;
            end
            axon_q       <= '0;
            bprop_q      <= '0;
            deriv_q      <= '0;
            delta_q      <= '0;
            rate_q       <= '0;
            issue_q      <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
            out_change_q <= '0;
            out_weight_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    dend_q[i] <= bp_dendrites[i*DATA_W +: DATA_W];
                end
                for (int i = 0; i <= N_INPUTS; i++) begin
                    wgt_q[i] <= bp_weights[i*DATA_W +: DATA_W];
                end
                axon_q  <= bp_axon;
                bprop_q <= bp_backprop;
                rate_q  <= bp_rate_shift;
                issue_q <= '0;
            end
            if (state_q == S_DRV) begin
                deriv_q <= scal_res;
            end
            if (state_q == S_DELTA) begin
                delta_q <= scal_res;
            end
            if (out_fire && out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (load) begin
                out_valid_q  <= 1'b1;
                out_idx_q    <= issue_q;
                out_change_q <= last_sel ? '0 : scal_res;
                out_weight_q <= w_new;
                out_last_q   <= last_sel;
                issue_q      <= issue_q + IDX_W'(1);
            end
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_change = out_change_q;
    assign out_weight = out_weight_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_backprop_engine.sv
// Self-checking bench for backprop_engine: a queue-based reference model checked every cycle,
// directed literal cases, backpressure, mid-stream reset and randomized bundles.
module tb_backprop_engine;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int IW = $clog2(N + 1);

    typedef struct {
        longint idx;
        longint change;
        longint weight;
        bit     last;
    } elem_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      bp_dendrites;
    logic [(N+1)*DW-1:0]  bp_weights;
    logic [DW-1:0]        bp_axon, bp_backprop;
    logic [4:0]           bp_rate_shift;
    logic                 out_valid, out_ready, out_last;
    logic [IW-1:0]        out_idx;
    logic [DW-1:0]        out_change, out_weight;

    int   ready_mode = 0;   // 0: always ready, 1: stalled, 2: random
    logic rnd_ready  = 1'b1;
    assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 0);

    always #5 clk = ~clk;

    backprop_engine #(.N_INPUTS(N), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .bp_dendrites(bp_dendrites), .bp_weights(bp_weights),
        .bp_axon(bp_axon), .bp_backprop(bp_backprop), .bp_rate_shift(bp_rate_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_change(out_change), .out_weight(out_weight), .out_last(out_last)
    );

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     first_cyc = 0;
    bit     busy = 1'b0;
    elem_t  exp_q[$];
    elem_t  mon_e;
    longint got_change [N+1];
    longint got_weight [N+1];
    longint got_last   [N+1];
    int     emit_count [N+1];
    int     stream_cnt = 0;

    logic signed [DW-1:0] dset [N];
    logic signed [DW-1:0] wset [N+1];
    logic signed [DW-1:0] axs, bps;
    logic [4:0]           rs;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected stream for the bundle currently on the input bus, straight from the arithmetic rules.
    function automatic void push_model();
        longint ax, bp, deriv, delta, dv, wv, term;
        int     sh;
        elem_t  e;
        ax    = longint'($signed(bp_axon));
        bp    = longint'($signed(bp_backprop));
        sh    = int'(bp_rate_shift);
        deriv = sat16((ax * ((longint'(1) << FW) - ax)) >>> FW);
        delta = sat16((bp * deriv) >>> FW);
        for (int i = 0; i <= N; i++) begin
            wv = longint'($signed(bp_weights[i*DW +: DW]));
            if (i < N) begin
                dv       = longint'($signed(bp_dendrites[i*DW +: DW]));
                e.change = sat16((delta * wv) >>> FW);
                term     = sat16((delta * dv) >>> FW) >>> sh;
            end else begin
                e.change = 0;
                term     = delta >>> sh;
            end
            e.weight = sat16(wv + term);
            e.idx    = i;
            e.last   = (i == N);
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare process: checks the handshake signals and every valid element against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("in_ready", longint'(in_ready), longint'(!busy));
            check("out_valid", longint'(out_valid), longint'(busy && cyc >= first_cyc));
            if (out_valid && exp_q.size() > 0) begin
                mon_e = exp_q[0];
                check("out_idx", longint'(out_idx), mon_e.idx);
                check("out_change", longint'($signed(out_change)), mon_e.change);
                check("out_weight", longint'($signed(out_weight)), mon_e.weight);
                check("out_last", longint'(out_last), longint'(mon_e.last));
                if (out_ready && !rst) begin
                    got_change[mon_e.idx] = longint'($signed(out_change));
                    got_weight[mon_e.idx] = longint'($signed(out_weight));
                    got_last[mon_e.idx]   = longint'(out_last);
                    emit_count[mon_e.idx]++;
                    stream_cnt++;
                    void'(exp_q.pop_front());
                    if (mon_e.last) busy = 1'b0;
                end
            end
            if (rst) begin
                exp_q.delete();
                busy = 1'b0;
            end else if (in_valid && in_ready) begin
                for (int i = 0; i <= N; i++) begin
                    got_change[i] = -99999;
                    got_weight[i] = -99999;
                    got_last[i]   = -1;
                    emit_count[i] = 0;
                end
                stream_cnt = 0;
                push_model();
                busy      = 1'b1;
                first_cyc = cyc + 4;
            end
        end
    end

    function automatic logic signed [DW-1:0] rnd16();
        if ($urandom_range(0, 1) == 0) return DW'($urandom);
        return DW'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    task automatic random_bundle();
        for (int i = 0; i < N; i++) dset[i] = rnd16();
        for (int i = 0; i <= N; i++) wset[i] = rnd16();
        axs = ($urandom_range(0, 3) != 0) ? DW'($urandom_range(0, 256)) : rnd16();
        bps = rnd16();
        rs  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
    endtask

    task automatic garbage_bus();
        for (int i = 0; i < N; i++) bp_dendrites[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i <= N; i++) bp_weights[i*DW +: DW] = DW'($urandom);
        bp_axon       = DW'($urandom);
        bp_backprop   = DW'($urandom);
        bp_rate_shift = 5'($urandom);
    endtask

    // Called and returns just after a rising edge; the bus is scrambled once the bundle is taken.
    task automatic send();
        int t = 0;
        while (!in_ready) begin
            in_valid = 1'($urandom_range(0, 1));
            garbage_bus();
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) begin
                in_valid = 1'b0;
                fail_now("send_wait_in_ready");
                return;
            end
        end
        for (int i = 0; i < N; i++) bp_dendrites[i*DW +: DW] = dset[i];
        for (int i = 0; i <= N; i++) bp_weights[i*DW +: DW] = wset[i];
        bp_axon       = axs;
        bp_backprop   = bps;
        bp_rate_shift = rs;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        garbage_bus();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy || !in_ready) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) begin
                fail_now("wait_idle");
                return;
            end
        end
    endtask

    task automatic wait_idx(input int k);
        int t = 0;
        while (!(out_valid && int'(out_idx) == k)) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                fail_now("wait_idx");
                return;
            end
        end
    endtask

    task automatic basic_bundle();
        random_bundle();
        axs     = 16'sd128;
        bps     = 16'sd256;
        dset[0] = 16'sd256;
        wset[0] = 16'sd512;
        wset[N] = 16'sd256;
        rs      = 5'd2;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        ready_mode = 0;
        garbage_bus();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_out_change", longint'(out_change), 0);
        check("rst_out_weight", longint'(out_weight), 0);
        check("rst_out_last", longint'(out_last), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic and threshold element
        basic_bundle();
        send();
        wait_idle();
        check("basic_change0", got_change[0], 128);
        check("basic_weight0", got_weight[0], 528);
        check("thr_change", got_change[N], 0);
        check("thr_weight", got_weight[N], 272);
        check("thr_last", got_last[N], 1);
        check("basic_count", stream_cnt, N + 1);

        // Saturation
        random_bundle();
        axs = 16'sd128; bps = 16'sd32767; dset[0] = 16'sd32767; wset[0] = 16'sd32767; rs = 5'd0;
        send();
        wait_idle();
        check("sat_change0", got_change[0], 32767);
        check("sat_weight0", got_weight[0], 32767);

        // Negative values with floor shifts
        random_bundle();
        axs = 16'sd128; bps = -16'sd256; dset[0] = 16'sd256; wset[0] = 16'sd0; rs = 5'd3;
        send();
        wait_idle();
        check("neg_change0", got_change[0], 0);
        check("neg_weight0", got_weight[0], -8);

        // Backpressure at idx 3
        basic_bundle();
        send();
        wait_idx(3);
        ready_mode = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("bp_hold_idx", longint'(out_idx), 3);
        check("bp_hold_valid", longint'(out_valid), 1);
        ready_mode = 0;
        wait_idle();
        check("bp_idx3_once", emit_count[3], 1);
        check("bp_count", stream_cnt, N + 1);

        // Reset in the middle of a stream
        basic_bundle();
        send();
        wait_idx(10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        basic_bundle();
        send();
        wait_idle();
        check("post_rst_change0", got_change[0], 128);
        check("post_rst_weight0", got_weight[0], 528);
        check("post_rst_count", stream_cnt, N + 1);

        // Randomized bundles with random consumer stalls
        ready_mode = 2;
        for (int b = 0; b < 30; b++) begin
            random_bundle();
            send();
        end
        wait_idle();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
